// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU between two requesters,
// holding operands for the ALU latency and returning the result to the issuer.
module alu_arbiter #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ALU_LATENCY = 1,
   parameter logic [2:0]  IDLE_OP     = 3'b111
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [2:0]            req0_op,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   input  logic [2:0]            req1_op,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_result,
   output logic                  rsp0_eq,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_result,
   output logic                  rsp1_eq,
   output logic [DATA_WIDTH-1:0] alu_in1,
   output logic [DATA_WIDTH-1:0] alu_in2,
   output logic [2:0]            alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_eq,
   output logic                  busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [2:0] LAT_CNT = 3'(ALU_LATENCY);

   logic [1:0]            state_q, state_d;
   logic                  lastGrant_q, lastGrant_d;
   logic                  owner_q, owner_d;
   logic [DATA_WIDTH-1:0] holdA_q, holdA_d;
   logic [DATA_WIDTH-1:0] holdB_q, holdB_d;
   logic [2:0]            holdOp_q, holdOp_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  eq_q, eq_d;

   logic grant0, grant1, rspHandshake;

   // Ready is masked by reset so nothing is offered while the block is held in reset.
   assign grant0 = rst_n && (state_q == S_IDLE) && req0_valid && (!req1_valid || lastGrant_q);
   assign grant1 = rst_n && (state_q == S_IDLE) && req1_valid && (!req0_valid || !lastGrant_q);

   assign req0_ready   = grant0;
   assign req1_ready   = grant1;
   assign rspHandshake = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      owner_d     = owner_q;
      holdA_d     = holdA_q;
      holdB_d     = holdB_q;
      holdOp_d    = holdOp_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      eq_d        = eq_q;
      case (state_q)
         S_IDLE: begin
            if (grant0 || grant1) begin
               holdA_d     = grant1 ? req1_a  : req0_a;
               holdB_d     = grant1 ? req1_b  : req0_b;
               holdOp_d    = grant1 ? req1_op : req0_op;
               owner_d     = grant1;
               lastGrant_d = grant1;
               cnt_d       = 3'd0;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAT_CNT) begin
               result_d = alu_out;
               eq_d     = alu_eq;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (rspHandshake) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         holdA_q     <= '0;
         holdB_q     <= '0;
         holdOp_q    <= 3'd0;
         cnt_q       <= 3'd0;
         result_q    <= '0;
         eq_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         owner_q     <= owner_d;
         holdA_q     <= holdA_d;
         holdB_q     <= holdB_d;
         holdOp_q    <= holdOp_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         eq_q        <= eq_d;
      end
   end

   // The ALU sees the held operation only while it is in flight.
   assign alu_in1  = (state_q == S_EXEC) ? holdA_q  : '0;
   assign alu_in2  = (state_q == S_EXEC) ? holdB_q  : '0;
   assign alu_ctrl = (state_q == S_EXEC) ? holdOp_q : IDLE_OP;

   assign rsp0_valid  = (state_q == S_RESP) && !owner_q;
   assign rsp1_valid  = (state_q == S_RESP) &&  owner_q;
   assign rsp0_result = result_q;
   assign rsp1_result = result_q;
   assign rsp0_eq     = eq_q;
   assign rsp1_eq     = eq_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: two instances (ALU latency 1 and 2), each
// with a behavioural ALU, driven one at a time and compared against a scoreboard model.
module tb_alu_arbiter;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic sel;

   logic          req0Valid, req1Valid, rsp0Ready, rsp1Ready;
   logic [DW-1:0] req0A, req0B, req1A, req1B;
   logic [2:0]    req0Op, req1Op;

   logic          req0ReadyA, req1ReadyA, rsp0ValidA, rsp1ValidA, rsp0EqA, rsp1EqA, aluEqA, busyA;
   logic [DW-1:0] rsp0ResultA, rsp1ResultA, aluIn1A, aluIn2A, aluOutA;
   logic [2:0]    aluCtrlA;
   logic          req0ReadyB, req1ReadyB, rsp0ValidB, rsp1ValidB, rsp0EqB, rsp1EqB, aluEqB, busyB;
   logic [DW-1:0] rsp0ResultB, rsp1ResultB, aluIn1B, aluIn2B, aluOutB;
   logic [2:0]    aluCtrlB;

   int errors = 0;
   int checks = 0;
   bit lastGrantModel [2];

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference ALU behaviour: add, subtract, and, or, xor; other codes pass a through.
   function automatic logic [DW-1:0] aluRef(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   // One-stage registered ALU model serving the latency-1 instance.
   logic [DW:0] pipeA = '0;
   always_ff @(posedge clk) pipeA <= {aluIn1A == aluIn2A, aluRef(aluCtrlA, aluIn1A, aluIn2A)};
   assign aluOutA = pipeA[DW-1:0];
   assign aluEqA  = pipeA[DW];

   // Two-stage registered ALU model serving the latency-2 instance.
   logic [DW:0] pipeB0 = '0;
   logic [DW:0] pipeB1 = '0;
   always_ff @(posedge clk) begin
      pipeB0 <= {aluIn1B == aluIn2B, aluRef(aluCtrlB, aluIn1B, aluIn2B)};
      pipeB1 <= pipeB0;
   end
   assign aluOutB = pipeB1[DW-1:0];
   assign aluEqB  = pipeB1[DW];

   alu_arbiter #(.DATA_WIDTH(DW), .ALU_LATENCY(1), .IDLE_OP(3'b111)) u_dutA (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0Valid & ~sel), .req0_ready(req0ReadyA), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
      .req1_valid(req1Valid & ~sel), .req1_ready(req1ReadyA), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
      .rsp0_valid(rsp0ValidA), .rsp0_ready(rsp0Ready & ~sel), .rsp0_result(rsp0ResultA), .rsp0_eq(rsp0EqA),
      .rsp1_valid(rsp1ValidA), .rsp1_ready(rsp1Ready & ~sel), .rsp1_result(rsp1ResultA), .rsp1_eq(rsp1EqA),
      .alu_in1(aluIn1A), .alu_in2(aluIn2A), .alu_ctrl(aluCtrlA), .alu_out(aluOutA), .alu_eq(aluEqA),
      .busy(busyA)
   );

   alu_arbiter #(.DATA_WIDTH(DW), .ALU_LATENCY(2), .IDLE_OP(3'b111)) u_dutB (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0Valid & sel), .req0_ready(req0ReadyB), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
      .req1_valid(req1Valid & sel), .req1_ready(req1ReadyB), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
      .rsp0_valid(rsp0ValidB), .rsp0_ready(rsp0Ready & sel), .rsp0_result(rsp0ResultB), .rsp0_eq(rsp0EqB),
      .rsp1_valid(rsp1ValidB), .rsp1_ready(rsp1Ready & sel), .rsp1_result(rsp1ResultB), .rsp1_eq(rsp1EqB),
      .alu_in1(aluIn1B), .alu_in2(aluIn2B), .alu_ctrl(aluCtrlB), .alu_out(aluOutB), .alu_eq(aluEqB),
      .busy(busyB)
   );

   // The selected instance's outputs, so the checking tasks work on either one.
   logic          oReq0Ready, oReq1Ready, oRsp0Valid, oRsp1Valid, oRsp0Eq, oRsp1Eq, oBusy;
   logic [DW-1:0] oRsp0Result, oRsp1Result, oAluIn1, oAluIn2;
   logic [2:0]    oAluCtrl;
   assign oReq0Ready  = sel ? req0ReadyB  : req0ReadyA;
   assign oReq1Ready  = sel ? req1ReadyB  : req1ReadyA;
   assign oRsp0Valid  = sel ? rsp0ValidB  : rsp0ValidA;
   assign oRsp1Valid  = sel ? rsp1ValidB  : rsp1ValidA;
   assign oRsp0Eq     = sel ? rsp0EqB     : rsp0EqA;
   assign oRsp1Eq     = sel ? rsp1EqB     : rsp1EqA;
   assign oRsp0Result = sel ? rsp0ResultB : rsp0ResultA;
   assign oRsp1Result = sel ? rsp1ResultB : rsp1ResultA;
   assign oAluIn1     = sel ? aluIn1B     : aluIn1A;
   assign oAluIn2     = sel ? aluIn2B     : aluIn2A;
   assign oAluCtrl    = sel ? aluCtrlB    : aluCtrlA;
   assign oBusy       = sel ? busyB       : busyA;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Idle-state outputs: no grant, no response, ALU parked.
   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_busy"}, oBusy, 1'b0);
      checkOutput({tag, "_rspValid"}, {oRsp0Valid, oRsp1Valid}, 2'b00);
      checkOutput({tag, "_alu"}, {oAluIn1, oAluIn2, oAluCtrl}, {{(2*DW){1'b0}}, 3'b111});
   endtask

   // Runs one full operation from the IDLE cycle to the IDLE cycle after the response.
   // Must be entered at the start of the IDLE cycle; stall = cycles the owner withholds rsp ready.
   task automatic applyStimulus(input logic v0, input logic v1,
                                input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [2:0] op0,
                                input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [2:0] op1,
                                input int stall);
      int            lat;
      int            g;
      logic [DW-1:0] ea, eb, expRes;
      logic [2:0]    eop;
      logic          expEq;
      lat = sel ? 2 : 1;
      g   = (v0 && v1) ? (lastGrantModel[sel] ? 0 : 1) : (v0 ? 0 : 1);
      ea  = g ? a1 : a0;
      eb  = g ? b1 : b0;
      eop = g ? op1 : op0;
      expRes = aluRef(eop, ea, eb);
      expEq  = (ea == eb);
      #1 checkIdleOutputs("idle");
      req0Valid = v0; req0A = a0; req0B = b0; req0Op = op0;
      req1Valid = v1; req1A = a1; req1B = b1; req1Op = op1;
      if (g == 0) begin
         rsp0Ready = (stall == 0); rsp1Ready = 1'($urandom_range(0, 1));
      end else begin
         rsp1Ready = (stall == 0); rsp0Ready = 1'($urandom_range(0, 1));
      end
      #1 checkOutput("grant", {oReq0Ready, oReq1Ready}, {g == 0, g == 1});
      @(posedge clk);
      lastGrantModel[sel] = (g == 1);
      @(negedge clk);
      for (int k = 0; k <= lat; k++) begin
         #1;
         checkOutput("exec_alu", {oAluIn1, oAluIn2, oAluCtrl}, {ea, eb, eop});
         checkOutput("exec_ctl", {oBusy, oRsp0Valid, oRsp1Valid, oReq0Ready, oReq1Ready}, 5'b10000);
         @(negedge clk);
      end
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) begin
            if (g == 0) rsp0Ready = 1'b1; else rsp1Ready = 1'b1;
         end
         #1;
         checkOutput("resp_ctl", {oBusy, oRsp0Valid, oRsp1Valid, oReq0Ready, oReq1Ready},
                     {1'b1, g == 0, g == 1, 2'b00});
         checkOutput("resp_data", g ? {oRsp1Result, oRsp1Eq} : {oRsp0Result, oRsp0Eq}, {expRes, expEq});
         checkOutput("resp_alu", {oAluIn1, oAluIn2, oAluCtrl}, {{(2*DW){1'b0}}, 3'b111});
         @(negedge clk);
      end
   endtask

   // Asynchronous reset pulse; leaves the bench at the start of an IDLE cycle.
   task automatic pulseReset();
      rst_n = 1'b0;
      lastGrantModel[0] = 1'b1;
      lastGrantModel[1] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Directed scenarios first, then randomized traffic on both latencies.
   initial begin
      logic [DW-1:0] ra0, rb0, ra1, rb1;
      logic [1:0]    vPat;
      sel = 1'b0;
      rst_n = 1'b0;
      req0Valid = 1'b1; req1Valid = 1'b1;
      req0A = '0; req0B = '0; req0Op = 3'd0;
      req1A = '0; req1B = '0; req1Op = 3'd0;
      rsp0Ready = 1'b0; rsp1Ready = 1'b0;
      lastGrantModel[0] = 1'b1;
      lastGrantModel[1] = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_ready", {oReq0Ready, oReq1Ready}, 2'b00);
      checkOutput("reset_result", {oRsp0Result, oRsp0Eq, oRsp1Result, oRsp1Eq}, '0);
      checkIdleOutputs("reset");
      req0Valid = 1'b0; req1Valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1, 0, 32'd5, 32'd7, 3'd0, '0, '0, 3'd0, 0);
      applyStimulus(0, 1, '0, '0, 3'd0, 32'd9, 32'd9, 3'd1, 0);
      applyStimulus(0, 1, '0, '0, 3'd0, 32'd3, 32'd5, 3'd1, 0);

      pulseReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1, 32'(100 + i), 32'(7 * i), 3'd0, 32'(50 + i), 32'(3 * i), 3'd4, 0);
      end

      applyStimulus(1, 1, 32'hF0F0_1234, 32'h0FF0_4321, 3'd3, 32'd40, 32'd2, 3'd1, 5);
      applyStimulus(0, 1, '0, '0, 3'd0, 32'd40, 32'd2, 3'd1, 0);

      // Drop an operation by resetting in its second EXEC cycle.
      req0Valid = 1'b1; req1Valid = 1'b0; req0A = 32'd4; req0B = 32'd4; req0Op = 3'd0; rsp0Ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      lastGrantModel[0] = 1'b1;
      #1;
      checkOutput("midrst_ready", {oReq0Ready, oReq1Ready}, 2'b00);
      checkOutput("midrst_result", {oRsp0Result, oRsp0Eq}, '0);
      checkIdleOutputs("midrst");
      req0Valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         #1 checkIdleOutputs("postrst");
         @(negedge clk);
      end
      applyStimulus(1, 0, 32'd1, 32'd1, 3'd0, '0, '0, 3'd0, 0);

      for (int i = 0; i < 20; i++) begin
         vPat = 2'($urandom_range(1, 3));
         ra0 = $urandom(); rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom();
         ra1 = $urandom(); rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom();
         applyStimulus(vPat[0], vPat[1], ra0, rb0, 3'($urandom_range(0, 7)),
                       ra1, rb1, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
      end

      req0Valid = 1'b0; req1Valid = 1'b0;
      sel = 1'b1;
      @(negedge clk);
      applyStimulus(1, 0, 32'd10, 32'd20, 3'd0, '0, '0, 3'd0, 0);
      for (int i = 0; i < 6; i++) begin
         vPat = 2'($urandom_range(1, 3));
         ra0 = $urandom(); rb0 = ($urandom_range(0, 2) == 0) ? ra0 : $urandom();
         ra1 = $urandom(); rb1 = $urandom();
         applyStimulus(vPat[0], vPat[1], ra0, rb0, 3'($urandom_range(0, 7)),
                       ra1, rb1, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between two requesters (req0, req1) using round-robin arbitration. It accepts one operation at a time over a valid/ready handshake and holds the operands stable on the ALU inputs for the ALU's pipeline latency. It then captures the ALU result and equality flag and returns them on the response port of the requester that issued the operation. It sits between the issuing units and the ALU instance and is the only driver of the ALU's operand and control inputs.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: operand and result width.
- `ALU_LATENCY`, default 1: clock edges from ALU inputs stable to `alu_out`/`alu_eq` valid. Legal range 1–7.
- `IDLE_OP`, default 3'b111: value driven on `alu_ctrl` when no operation is in flight.

**Ports**
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `reqN_valid` in 1 (N = 0, 1): requester N presents an operation.
- `reqN_ready` out 1: block accepts requester N this cycle.
- `reqN_a`, `reqN_b` in DATA_WIDTH: operands.
- `reqN_op` in 3: ALU control code, passed through unmodified.
- `rspN_valid` out 1: response for requester N is available.
- `rspN_ready` in 1: requester N accepts the response.
- `rspN_result` out DATA_WIDTH: captured ALU result.
- `rspN_eq` out 1: captured ALU equality flag.
- `alu_in1`, `alu_in2` out DATA_WIDTH: ALU operands.
- `alu_ctrl` out 3: ALU control.
- `alu_out` in DATA_WIDTH: ALU result.
- `alu_eq` in 1: ALU equality flag.
- `busy` out 1: high in every state except IDLE.

## Operation

**States**
- IDLE: waiting for a request.
- EXEC: operation in flight on the ALU.
- RESP: response held for the owning requester.

**Arbitration (IDLE only)**
- Exactly one `reqN_ready` may be high per cycle, and none outside IDLE.
- Only req0 valid: `req0_ready` = 1.
- Only req1 valid: `req1_ready` = 1.
- Both valid: grant the requester that is not `last_grant`.
- On a handshake (valid && ready):
  - latch a, b and op into the hold registers;
  - set `owner` = N and `last_grant` = N;
  - clear the latency counter `cnt`;
  - go to EXEC.

**EXEC**
- `alu_in1`/`alu_in2`/`alu_ctrl` driven from the hold registers, constant for the whole state.
- `cnt` increments each cycle.
- When `cnt` == ALU_LATENCY:
  - capture `alu_out` and `alu_eq` into the response registers;
  - go to RESP.
- EXEC therefore lasts ALU_LATENCY+1 cycles.

**RESP**
- `rsp<owner>_valid` = 1; the other response valid stays 0.
- Result and eq stay stable until `rsp<owner>_ready` = 1.
- On the response handshake, go to IDLE.

**Outside EXEC**
- `alu_in1` = `alu_in2` = 0 and `alu_ctrl` = IDLE_OP.

**Requester obligations**
- A requester keeps valid, a, b and op stable until ready.
- The block does not check this. Operands are sampled only at the handshake edge.

**Width and encoding**
- `cnt` is 3 bits.
- `op` is not decoded. Unsupported codes return whatever the ALU produces.

## Timing

**Reset (`rst_n` low, asynchronous)**
- state = IDLE; all `ready` and `rsp*_valid` = 0; `busy` = 0.
- Response result/eq = 0; hold registers = 0; `cnt` = 0.
- `last_grant` = 1, so req0 wins the first tie.
- `alu_ctrl` = IDLE_OP; `alu_in1` = `alu_in2` = 0.
- Reset asserted in EXEC or RESP drops the operation; no response is ever produced for it.

**Latency (request handshake at edge E)**
- EXEC occupies cycles E+1 … E+1+ALU_LATENCY.
- `rspN_valid` first high in the cycle after edge E+ALU_LATENCY+1. For ALU_LATENCY = 1 this is the 3rd cycle after E.

**Response and throughput**
- `rspN_ready` held high beforehand: `rspN_valid` is high for exactly 1 cycle.
- Back-to-back throughput: one operation per ALU_LATENCY+3 cycles, including the 1 IDLE cycle after each response handshake.

**Corner cases**
- A new request arriving during EXEC or RESP waits. Its ready stays 0 until IDLE.
- A non-owner `rsp_ready` is ignored.
- `rsp<owner>_ready` high during EXEC has no effect.
- Both requesters continuously valid: grants strictly alternate 0, 1, 0, 1, …

## Test plan

- **Single add:** req0 {a=5, b=7, op=000}, rsp0_ready=1 → req0_ready 1 cycle, rsp0_valid in the 3rd cycle after accept with result=12, eq=0; rsp1_valid stays 0.
- **Subtract equal:** req1 {a=9, b=9, op=001} → rsp1 result=0, eq=1. Then {a=3, b=5, op=001} → result=0xFFFFFFFE, eq=0.
- **Simultaneous after reset:** both valid with distinct ops held continuously for 8 operations → grant order 0, 1, 0, 1, …; each response goes to the correct port with the correct value.
- **Backpressure:** rsp0_ready=0 for 5 cycles → rsp0_valid/result/eq stable, busy=1, req1_ready=0 throughout. rsp0_ready=1 → IDLE next cycle, then req1 accepted.
- **Reset mid-operation:** assert rst_n=0 in the 2nd EXEC cycle → all outputs at reset values immediately, with no response. After release, req0 add 1+1 → result=2 with normal latency.
- **ALU_LATENCY=2:** with a 2-stage ALU model, req0 add 10+20 → rsp0_valid in the 4th cycle after accept, result=30; ALU inputs constant for all 3 EXEC cycles.
